// File: rtl/tdc_edge_decoder.sv
// Three-stage thermometer-to-binary decoder for one TDC delay-line column.
// Finds the highest bubble-filtered transition and flags missing/multiple edges.
module tdc_edge_decoder #(
  parameter int unsigned NUM_FF        = 64,
  parameter int unsigned BITS_DECO     = 8,
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned SEARCH_MARGIN = 20,
  parameter int unsigned ERR_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FF-1:0]    wTapsIn,
  input  logic                 wSampleValid,
  input  logic                 wEdgeMode,
  input  logic                 wErrClr,
  output logic [BITS_DECO-1:0] wBinOut,
  output logic                 wBinValid,
  output logic                 wNoEdge,
  output logic                 wMultiEdge,
  output logic [ERR_W-1:0]     wErrCount
);

  localparam int unsigned NumSearch = NUM_FF - SEARCH_MARGIN;

  // Stage 1: capture
  logic [NUM_FF-1:0] taps_q;
  logic              mode_q;
  logic              s1_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q     <= '0;
      mode_q     <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      taps_q     <= wTapsIn;
      mode_q     <= wEdgeMode;
      s1_valid_q <= wSampleValid;
    end
  end

  // Stage 2: match vector; falling mode reuses the rising matcher on the inverted line
  logic [NUM_FF-1:0]    line;
  logic [NumSearch-1:0] match_d;
  logic [NumSearch-1:0] match_q;
  logic                 s2_valid_q;

  assign line = mode_q ? ~taps_q : taps_q;

  for (genvar g = 0; g < NumSearch; g++) begin : g_match
    assign match_d[g] = ~line[g] & (&line[g+1 +: FILTER_LEN]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_q    <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      match_q    <= match_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Stage 3: highest-index priority encode plus zero/many detection
  logic [BITS_DECO-1:0] bin_d;
  logic                 any_d;
  logic                 multi_d;

  always_comb begin
    bin_d   = '0;
    any_d   = 1'b0;
    multi_d = 1'b0;
    for (int unsigned i = 0; i < NumSearch; i++) begin
      if (match_q[i]) begin
        multi_d = multi_d | any_d;
        any_d   = 1'b1;
        bin_d   = BITS_DECO'(i + 1);
      end
    end
  end

  logic [BITS_DECO-1:0] bin_q;
  logic                 no_edge_q;
  logic                 multi_edge_q;
  logic                 bin_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q        <= '0;
      no_edge_q    <= 1'b0;
      multi_edge_q <= 1'b0;
      bin_valid_q  <= 1'b0;
    end else begin
      bin_valid_q <= s2_valid_q;
      // Results hold while no sample is in the stage
      if (s2_valid_q) begin
        bin_q        <= bin_d;
        no_edge_q    <= ~any_d;
        multi_edge_q <= multi_d;
      end
    end
  end

  // Saturating error counter; clear beats a coincident error
  logic [ERR_W-1:0] err_q;
  logic             err_event;

  assign err_event = bin_valid_q & (no_edge_q | multi_edge_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (wErrClr) begin
      err_q <= '0;
    end else if (err_event && (err_q != {ERR_W{1'b1}})) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign wBinOut    = bin_q;
  assign wBinValid  = bin_valid_q;
  assign wNoEdge    = no_edge_q;
  assign wMultiEdge = multi_edge_q;
  assign wErrCount  = err_q;

endmodule

// File: tb/tb_tdc_edge_decoder.sv
// Directed-vector bench for tdc_edge_decoder: default instance plus a 2-bit
// error-counter instance sharing the same stimulus.
module tb_tdc_edge_decoder;

  logic        clk;
  logic        rst;
  logic [63:0] taps;
  logic        sample_valid;
  logic        edge_mode;
  logic        err_clr;

  logic [7:0]  bin;
  logic        bin_valid;
  logic        no_edge;
  logic        multi_edge;
  logic [15:0] err_count;

  logic [7:0]  bin2;
  logic        bin_valid2;
  logic        no_edge2;
  logic        multi_edge2;
  logic [1:0]  err_count2;

  int n_cmp = 0;
  int n_err = 0;
  int exp_err = 0;

  tdc_edge_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .wTapsIn      (taps),
    .wSampleValid (sample_valid),
    .wEdgeMode    (edge_mode),
    .wErrClr      (err_clr),
    .wBinOut      (bin),
    .wBinValid    (bin_valid),
    .wNoEdge      (no_edge),
    .wMultiEdge   (multi_edge),
    .wErrCount    (err_count)
  );

  tdc_edge_decoder #(.ERR_W(2)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .wTapsIn      (taps),
    .wSampleValid (sample_valid),
    .wEdgeMode    (edge_mode),
    .wErrClr      (err_clr),
    .wBinOut      (bin2),
    .wBinValid    (bin_valid2),
    .wNoEdge      (no_edge2),
    .wMultiEdge   (multi_edge2),
    .wErrCount    (err_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample: result 3 cycles later, error count one cycle after that
  task automatic run_one(input string tag, input logic [63:0] t, input logic m,
                         input int exp_bin, input logic exp_ne, input logic exp_me);
    taps         = t;
    edge_mode    = m;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    check({tag, ".early"}, 64'(bin_valid), 64'd0);
    step();
    check({tag, ".valid"}, 64'(bin_valid), 64'd1);
    check({tag, ".bin"}, 64'(bin), 64'(exp_bin));
    check({tag, ".noedge"}, 64'(no_edge), 64'(exp_ne));
    check({tag, ".multi"}, 64'(multi_edge), 64'(exp_me));
    step();
    if (exp_ne || exp_me) exp_err++;
    check({tag, ".pulse"}, 64'(bin_valid), 64'd0);
    check({tag, ".errcnt"}, 64'(err_count), 64'(exp_err));
  endtask

  int p;

  initial begin
    rst          = 1'b1;
    taps         = '0;
    sample_valid = 1'b0;
    edge_mode    = 1'b0;
    err_clr      = 1'b0;
    repeat (3) step();
    check("rst.valid", 64'(bin_valid), 64'd0);
    check("rst.bin", 64'(bin), 64'd0);
    check("rst.noedge", 64'(no_edge), 64'd0);
    check("rst.multi", 64'(multi_edge), 64'd0);
    check("rst.errcnt", 64'(err_count), 64'd0);
    rst = 1'b0;
    step();
    check("postrst.valid", 64'(bin_valid), 64'd0);

    run_one("clean",   64'hFFFF_FFFF_FFFF_FC00, 1'b0, 10, 1'b0, 1'b0);
    run_one("bubble",  64'hFFFF_FFFF_FFFF_F400, 1'b0, 12, 1'b0, 1'b0);
    run_one("multi",   64'hFFFF_FFFF_FFEF_FFE0, 1'b0, 21, 1'b0, 1'b1);
    run_one("allones", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,  0, 1'b1, 1'b0);
    run_one("margin",  64'hFFFC_0000_0000_0000, 1'b0,  0, 1'b1, 1'b0);
    run_one("topbin",  64'hFFFF_F000_0000_0000, 1'b0, 44, 1'b0, 1'b0);
    run_one("falling", 64'h0000_0000_3FFF_FFFF, 1'b1, 30, 1'b0, 1'b0);

    // Ten back-to-back samples, alternating mode, edge at bin 5+3k
    for (int c = 0; c < 13; c++) begin
      if (c < 10) begin
        p            = 5 + 3 * c;
        edge_mode    = c[0];
        taps         = c[0] ? ~({64{1'b1}} << p) : ({64{1'b1}} << p);
        sample_valid = 1'b1;
      end else begin
        sample_valid = 1'b0;
      end
      step();
      if (c >= 2 && c < 12) begin
        check($sformatf("stream%0d.valid", c - 2), 64'(bin_valid), 64'd1);
        check($sformatf("stream%0d.bin", c - 2), 64'(bin), 64'(5 + 3 * (c - 2)));
      end else if (c == 12) begin
        check("stream.tail", 64'(bin_valid), 64'd0);
      end
    end
    check("stream.errcnt", 64'(err_count), 64'(exp_err));

    // Reset in cycle 5; samples 0..2 emerge, 3..5 discarded, cycle-6 sample accepted
    edge_mode = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rst          = (c == 5);
      sample_valid = (c <= 6);
      taps         = {64{1'b1}} << (10 + c);
      step();
      if (c + 1 >= 3 && c + 1 <= 5) begin
        check($sformatf("rstmid.t%0d.valid", c + 1), 64'(bin_valid), 64'd1);
        check($sformatf("rstmid.t%0d.bin", c + 1), 64'(bin), 64'(10 + c - 2));
      end else if (c + 1 == 9) begin
        check("rstmid.post.valid", 64'(bin_valid), 64'd1);
        check("rstmid.post.bin", 64'(bin), 64'd16);
      end else begin
        check($sformatf("rstmid.t%0d.valid", c + 1), 64'(bin_valid), 64'd0);
      end
      if (c + 1 == 6) begin
        check("rstmid.bin0", 64'(bin), 64'd0);
        check("rstmid.errcnt", 64'(err_count), 64'd0);
      end
    end
    rst = 1'b0;
    sample_valid = 1'b0;
    exp_err = 0;
    step();

    // Saturation: five all-ones samples into the 2-bit counter
    taps = {64{1'b1}};
    for (int c = 0; c < 9; c++) begin
      sample_valid = (c < 5);
      step();
      if (c + 1 >= 4) begin
        check($sformatf("sat.t%0d", c + 1), 64'(err_count2),
              64'((c + 1 - 3) > 3 ? 3 : (c + 1 - 3)));
      end
    end
    check("sat.wide", 64'(err_count), 64'd5);

    // Clear coincident with an error, then count the next error
    for (int c = 0; c < 7; c++) begin
      sample_valid = (c < 2);
      err_clr      = (c == 3);
      step();
      if (c + 1 <= 3) begin
        check($sformatf("clr.t%0d", c + 1), 64'(err_count2), 64'd3);
      end else if (c + 1 == 4) begin
        check("clr.zero", 64'(err_count2), 64'd0);
        check("clr.zero.wide", 64'(err_count), 64'd0);
      end else begin
        check($sformatf("clr.t%0d", c + 1), 64'(err_count2), 64'd1);
      end
    end
    err_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
